unidad_fetch: RTL
=================

# unidad_fetch

Instruction fetch unit: the initiator side of the instruction-memory read interface. It generates the program counter, drives the active-low `ReadMem` strobe and `Dir_Instru` address into the instruction memory, and captures `Dato_Instru` one cycle later. It presents each captured instruction, with its PC, to the decode stage through a valid/ready handshake. It supports redirect (branch/jump) with flush and stops after the last program word.

## Interface
- `PC_RESET`, default 32'h00400000: first fetch address after reset.
- `PC_LAST`, default 32'h00400038: address of the final program word; its delivery ends fetching.
- `clk`  in  1  system clock; all state on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ReadMem`  out  1  memory read strobe, active low; memory samples it on the rising edge.
- `Dir_Instru`  out  32  memory address; always equals the internal PC register.
- `Dato_Instru`  in  32  memory data; valid only in the cycle after a strobe cycle (memory drives 0 otherwise).
- `salto`  in  1  redirect request, sampled on the rising edge.
- `dir_salto`  in  32  redirect target; bits [1:0] are forced to 0.
- `instr`  out  32  buffered instruction.
- `pc_instr`  out  32  address the buffered instruction was fetched from.
- `instr_valid`  out  1  buffer holds an undelivered instruction.
- `instr_ready`  in  1  decode accepts; transfer when `instr_valid` && `instr_ready` at a rising edge.
- `done`  out  1  last program word delivered; fetching stopped.
- `instr_count`  out  16  handshakes completed since reset; saturates at 16'hFFFF.

## Operation
- States: ISSUE, WAIT, HOLD, DONE. After reset the FSM is in ISSUE.
- ISSUE:
  - `ReadMem`=0.
  - Next state is WAIT.
- WAIT:
  - `ReadMem`=1.
  - At the edge: `instr`<=`Dato_Instru`, `pc_instr`<=PC, `instr_valid`<=1, PC<=PC+4 (mod 2^32).
  - Next state is HOLD.
- HOLD:
  - `ReadMem`=1; `instr_valid`=1.
  - On a transfer: `instr_valid`<=0 and `instr_count` increments.
  - If `pc_instr`==`PC_LAST` at the transfer, next state is DONE; otherwise ISSUE.
  - Without a transfer the FSM stays in HOLD and `instr`/`pc_instr` stay stable.
- DONE:
  - `ReadMem`=1, `done`=1, `instr_valid`=0.
  - The FSM leaves DONE only on `salto` or `reset`.
- Redirect (`salto`=1 at an edge, any state):
  - PC<={`dir_salto`[31:2],2'b00}.
  - Any in-flight read is discarded: a WAIT-cycle capture does not occur.
  - `instr_valid`<=0, `done`<=0, next state ISSUE.
- Redirect simultaneous with a transfer in HOLD: the transfer completes (`instr_count` increments) and the redirect is then applied.
- Redirect has priority over all other transitions; `reset` has priority over redirect.
- Fetch addresses outside the program return 0 from memory and are delivered as 0 instructions. Only the `pc_instr`==`PC_LAST` condition sets `done`.
- PC wraps from 32'hFFFFFFFC to 0 without error.

## Timing
- Reset values (applied asynchronously while `reset`=1):
  - `ReadMem`=1, `Dir_Instru`=`PC_RESET`.
  - `instr`=0, `pc_instr`=0, `instr_valid`=0, `done`=0, `instr_count`=0.
  - State ISSUE.
- Reset asserted mid-operation discards any pending read and any buffered instruction immediately.
- First cycle after reset release:
  - `ReadMem`=0 and `Dir_Instru`=`PC_RESET`.
  - Memory latches at edge E1; the fetch unit captures at edge E2.
  - `instr_valid`=1 from E2.
- Latency from a transfer edge T to the next `instr_valid`=1 is 2 edges (T+2). With `instr_ready` held at 1, throughput is one instruction per 3 cycles.
- Latency from a redirect edge to the first `instr_valid` from the target is 2 edges.
- `ReadMem`=0 for exactly one cycle per fetch. `Dir_Instru` is stable during the ISSUE cycle and the following WAIT cycle.
- No combinational path from `instr_ready` or `salto` to `ReadMem` or `Dir_Instru`.

## Test plan
- Reset release, `instr_ready`=1 → `ReadMem` goes low in the first cycle at 0x00400000; `instr`=0x00000010 with `pc_instr`=0x00400000 at E2; next `instr`=0x01000110 with `pc_instr`=0x00400004 at E5.
- Full program, `instr_ready`=1 → 15 transfers from 0x00400000 to 0x00400038; `done`=1 after the last one, `instr_count`=15, no further `ReadMem` pulses.
- Hold `instr_ready`=0 for 5 cycles during HOLD → `instr` and `pc_instr` stay stable, no `ReadMem` pulse; releasing it gives exactly one transfer.
- `salto`=1 with `dir_salto`=0x00400023 during WAIT → capture suppressed; next strobe at 0x00400020; `instr`=0x001000011 (truncated to 32 bits) with `pc_instr`=0x00400020.
- `salto` with a transfer in HOLD, and separately `salto` in DONE → `instr_count` increments in the first case; `done` clears and fetching resumes at the target in the second.
- `reset` pulse during WAIT → outputs return to reset values within the same cycle; after release, fetching restarts at 0x00400000.

Source files
------------

// File: rtl/unidad_fetch.sv
// Instruction fetch unit: drives the instruction-memory read strobe and address,
// captures the returned word one cycle later and hands it to decode over a
// valid/ready handshake. Supports redirect with flush and stops after PC_LAST.
module unidad_fetch #(
    parameter logic [31:0] PC_RESET = 32'h00400000,
    parameter logic [31:0] PC_LAST  = 32'h00400038
) (
    input  logic        clk,
    input  logic        reset,
    output logic        ReadMem,
    output logic [31:0] Dir_Instru,
    input  logic [31:0] Dato_Instru,
    input  logic        salto,
    input  logic [31:0] dir_salto,
    output logic [31:0] instr,
    output logic [31:0] pc_instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        done,
    output logic [15:0] instr_count
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CW   = 16;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_instr;
    logic [XLEN-1:0]   r_pc_instr;
    logic              r_valid;
    logic              r_done;
    logic [CW-1:0]     r_count;

    logic              w_xfer;
    logic              w_last;
    logic [XLEN-1:0]   w_target;

    assign w_xfer   = (r_state == S_HOLD) && r_valid && instr_ready;
    assign w_last   = (r_pc_instr == PC_LAST);
    assign w_target = dir_salto & ~XLEN'(3);

    // Strobe is a pure state decode; reset forces it inactive while asserted.
    assign ReadMem     = reset | (r_state != S_ISSUE);
    assign Dir_Instru  = r_pc;
    assign instr       = r_instr;
    assign pc_instr    = r_pc_instr;
    assign instr_valid = r_valid;
    assign done        = r_done;
    assign instr_count = r_count;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; redirect overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  w_next_state = S_HOLD;
            S_HOLD: begin
                if (w_xfer) begin
                    w_next_state = w_last ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  w_next_state = S_DONE;
            default: w_next_state = S_ISSUE;
        endcase
        if (salto) begin
            w_next_state = S_ISSUE;
        end
    end

    // PC, instruction buffer, done flag and handshake counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc       <= PC_RESET;
            r_instr    <= '0;
            r_pc_instr <= '0;
            r_valid    <= 1'b0;
            r_done     <= 1'b0;
            r_count    <= '0;
        end else begin
            // A transfer coinciding with a redirect still completes.
            if (w_xfer && (r_count != {CW{1'b1}})) begin
                r_count <= r_count + CW'(1);
            end
            if (salto) begin
                r_pc    <= w_target;
                r_valid <= 1'b0;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    S_WAIT: begin
                        r_instr    <= Dato_Instru;
                        r_pc_instr <= r_pc;
                        r_valid    <= 1'b1;
                        r_pc       <= r_pc + XLEN'(4);
                    end
                    S_HOLD: begin
                        if (w_xfer) begin
                            r_valid <= 1'b0;
                            if (w_last) begin
                                r_done <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
